// File: rtl/imem_patch_ctrl.sv
// imem_patch_ctrl
//   Buffers keyboard patch codes and applies them to the instruction memory
//   only while the CPU fetch address sits at a safe point outside the patched
//   loop. Each patch drives WriteEnable high for HOLD_CYCLES clocks with a
//   stable keyboard value. The memory samples on the falling clock edge.
//
//   Optional feature: define KEY_DEDUP_EN to drop an accepted code that
//   repeats the previously accepted code. The handshake still completes.
//
// Ports
//   CLK, RESET_N   rising-edge clock, asynchronous active-low reset
//   key_valid/key_code/key_ready   6-bit key code input handshake
//   pc             current CPU fetch address
//   WriteEnable    patch strobe to the instruction memory
//   keyboard       patch data to the instruction memory
//   busy           high whenever the sequencer is not idle
//   overflow       sticky; a code was offered while key_ready was low
module imem_patch_ctrl #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [31:0] SAFE_PC     = 32'h0000_0050
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        key_valid,
  input  logic [5:0]  key_code,
  output logic        key_ready,
  input  logic [31:0] pc,
  output logic        WriteEnable,
  output logic [5:0]  keyboard,
  output logic        busy,
  output logic        overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SAFE, WRITE, SETTLE} state_t;

  state_t        state, state_nx;
  logic [5:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [HW-1:0] hcnt;
  logic          full, empty, pop, accept, push, load;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // The head leaves the FIFO in the last WRITE cycle.
  assign pop   = (state == WRITE) && (hcnt == '0);
  // A slot frees up in the pop cycle, so a full FIFO may still take a code
  // then. pop depends only on registered state, so there is no comb loop.
  assign key_ready = !full || pop;
  assign accept    = key_valid && key_ready;

`ifdef KEY_DEDUP_EN
  logic [5:0] last_code;
  assign push = accept && (key_code != last_code);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    last_code <= 6'h3F;
    else if (accept) last_code <= key_code;
  end
`else
  assign push = accept;
`endif

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE:      if (!empty) state_nx = WAIT_SAFE;
      WAIT_SAFE: if (pc == SAFE_PC) begin
                   state_nx = WRITE;
                   load     = 1'b1;
                 end
      WRITE:     if (hcnt == '0) state_nx = SETTLE;
      SETTLE:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      keyboard <= 6'd0;
      hcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      // keyboard only changes on entry to WRITE and stays stable for every
      // falling edge on which the memory samples it.
      if (load) begin
        keyboard <= mem[rd_ptr];
        hcnt     <= HW'(HOLD_CYCLES - 1);
      end else if ((state == WRITE) && (hcnt != '0)) begin
        hcnt <= hcnt - 1'b1;
      end
      if (key_valid && !key_ready) overflow <= 1'b1;
    end
  end

  // WriteEnable comes straight from the state register, so it is glitch-free
  // and drops as soon as reset is asserted.
  assign WriteEnable = (state == WRITE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_imem_patch_ctrl.sv
module tb_imem_patch_ctrl;
  localparam int          HOLD = 2;
  localparam logic [31:0] SAFE = 32'h0000_0050;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        key_valid = 1'b0;
  logic [5:0]  key_code = 6'd0;
  logic        key_ready;
  logic [31:0] pc = 32'd0;
  logic        WriteEnable;
  logic [5:0]  keyboard;
  logic        busy;
  logic        overflow;

  imem_patch_ctrl #(.FIFO_DEPTH(4), .HOLD_CYCLES(HOLD), .SAFE_PC(SAFE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .pc(pc), .WriteEnable(WriteEnable),
    .keyboard(keyboard), .busy(busy), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [5:0] exp_q[$];
  logic [5:0] obs_code[$];
  int         obs_len[$];
  logic [5:0] last_acc = 6'h3F;
  logic       exp_ovf = 1'b0;

  // Write monitor: collects each WriteEnable pulse (code, length) as seen on
  // the falling edge where the memory samples, and flags rule violations.
  logic        we_d = 1'b0;
  logic [31:0] pc_d = 32'd0;
  logic [5:0]  run_code = 6'd0;
  int          run_len = 0;
  int          pc_bad = 0;
  int          kb_bad = 0;

  always @(negedge CLK) begin
    if (WriteEnable) begin
      if (!we_d) begin
        run_code = keyboard;
        run_len  = 0;
        if (pc_d !== SAFE) pc_bad++;
      end else if (keyboard !== run_code) begin
        kb_bad++;
      end
      run_len++;
    end else if (we_d) begin
      obs_code.push_back(run_code);
      obs_len.push_back(run_len);
    end
    we_d = WriteEnable;
    pc_d = pc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: the queue of codes that must be written, in order.
  task automatic model_accept(input logic [5:0] c);
`ifdef KEY_DEDUP_EN
    if (c != last_acc) exp_q.push_back(c);
`else
    exp_q.push_back(c);
`endif
    last_acc = c;
  endtask

  task automatic offer(input logic [5:0] c);
    key_valid = 1'b1;
    key_code  = c;
    if (key_ready) model_accept(c);
    else exp_ovf = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_code.delete();
    obs_len.delete();
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    RESET_N   = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N  = 1'b1;
    clear_q();
    last_acc = 6'h3F;
    exp_ovf  = 1'b0;
  endtask

  task automatic wait_we(input string tag);
    for (int i = 0; i < 10 && !WriteEnable; i++) tick();
    check(tag, WriteEnable, 1);
  endtask

  task automatic cmp_writes(input string tag);
    int n;
    check({tag, "_nwrites"}, obs_code.size(), exp_q.size());
    n = (obs_code.size() < exp_q.size()) ? obs_code.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_code%0d", tag, i), obs_code[i], exp_q[i]);
      check($sformatf("%s_len%0d", tag, i), obs_len[i], HOLD);
    end
    clear_q();
  endtask

  initial begin
    logic [5:0] c;

    // 1: reset values, single patch latency and shape
    do_reset();
    check("rst_ready", key_ready, 1);
    check("rst_we", WriteEnable, 0);
    check("rst_kb", keyboard, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    pc = SAFE;
    offer(6'h15);
    for (int k = 1; k <= HOLD + 3; k++) begin
      tick();
      check($sformatf("t1_we_c%0d", k), WriteEnable, (k >= 2 && k <= 1 + HOLD));
      if (k >= 2 && k <= 1 + HOLD) check($sformatf("t1_kb_c%0d", k), keyboard, 6'h15);
      if (k == HOLD + 2) check("t1_busy_settle", busy, 1);
      if (k == HOLD + 3) check("t1_busy_idle", busy, 0);
    end
    cmp_writes("t1");

    // 2: no write until pc reaches the safe point
    pc = 32'h24;
    offer(6'h03);
    repeat (20) tick();
    check("t2_nowrite", obs_code.size(), 0);
    check("t2_busy", busy, 1);
    pc = SAFE;
    repeat (8) tick();
    cmp_writes("t2");

    // 3: fill past capacity, then drain in order
    pc = 32'h24;
    c = 6'($urandom_range(0, 31));
    if (c == last_acc) c ^= 6'h01;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_ready%0d", i), key_ready, exp_q.size() < 4);
      offer(c);
      c ^= {1'b0, 5'($urandom_range(1, 31))};
    end
    check("t3_ovf", overflow, 1);
    check("t3_full", key_ready, 0);
    pc = SAFE;
    repeat (4 * (HOLD + 3) + 6) tick();
    cmp_writes("t3");

    // 4: push into a full FIFO during the final WRITE cycle
    do_reset();
    pc = 32'h24;
    c = 6'($urandom_range(0, 31));
    for (int i = 0; i < 4; i++) begin
      offer(c);
      c ^= {1'b0, 5'($urandom_range(1, 31))};
    end
    check("t4_full", key_ready, 0);
    pc = SAFE;
    wait_we("t4_we_start");
    repeat (HOLD - 1) tick();
    check("t4_ready_on_pop", key_ready, 1);
    offer(6'h2A);
    check("t4_still_full", key_ready, 0);
    check("t4_no_ovf", overflow, 0);
    repeat (5 * (HOLD + 3) + 6) tick();
    cmp_writes("t4");

    // 5: reset in the middle of a write
    do_reset();
    pc = SAFE;
    offer(6'h2D);
    wait_we("t5_we_start");
    RESET_N = 1'b0;
    #1;
    check("t5_we_drop", WriteEnable, 0);
    check("t5_kb_clear", keyboard, 0);
    check("t5_busy_clear", busy, 0);
    repeat (2) @(posedge CLK);
    #1;
    clear_q();
    last_acc = 6'h3F;
    RESET_N  = 1'b1;
    repeat (12) tick();
    check("t5_no_write", obs_code.size(), 0);
    check("t5_ready", key_ready, 1);

    // 6: repeated code
    offer(6'h11);
    offer(6'h11);
    offer(6'h12);
    repeat (3 * (HOLD + 3) + 6) tick();
`ifdef KEY_DEDUP_EN
    check("t6_count", obs_code.size(), 2);
`else
    check("t6_count", obs_code.size(), 3);
`endif
    cmp_writes("t6");

    // Random traffic against the scoreboard
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      pc = ($urandom_range(0, 3) == 0) ? SAFE : ($urandom & 32'h0000_00FC);
      if ($urandom_range(0, 1) == 1) offer(6'($urandom));
      else tick();
    end
    key_valid = 1'b0;
    pc = SAFE;
    for (int i = 0; i < 400 && !(!busy && obs_code.size() == exp_q.size()); i++) tick();
    repeat (3) tick();
    check("rand_busy", busy, 0);
    check("rand_ovf", overflow, exp_ovf);
    cmp_writes("rand");
    check("pc_safe_at_start", pc_bad, 0);
    check("kb_stable", kb_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
